// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - data cache state type, geometry helpers and address field extraction
package dcache_pkg;

  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

  localparam int DEF_LINES          = 8;
  localparam int DEF_WORDS_PER_LINE = 4;

  function automatic int off_width(input int words_per_line);
    return 2 + $clog2(words_per_line);
  endfunction

  function automatic int index_width(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_width(input int lines, input int words_per_line);
    return 32 - off_width(words_per_line) - index_width(lines);
  endfunction

  // Field helpers return right-justified values; callers size them to the field width.
  function automatic logic [31:0] addr_index(input logic [31:0] addr, input int off);
    return addr >> off;
  endfunction

  function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int tag_lsb);
    return addr >> tag_lsb;
  endfunction

  function automatic logic [31:0] addr_word(input logic [31:0] addr);
    return addr >> 2;
  endfunction

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h3;
  endfunction

  function automatic logic [31:0] line_base(input logic [31:0] addr, input int off);
    return addr & ~((32'd1 << off) - 32'd1);
  endfunction

endpackage

// File: rtl/dcache_line_store.sv
// rtl/dcache_line_store.sv - valid/tag/data arrays with combinational lookup and synchronous updates
module dcache_line_store #(
  parameter int LINES = 8,
  parameter int WPL   = 4,
  parameter int IW    = 3,
  parameter int TW    = 25,
  parameter int WW    = 2
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [IW-1:0] index,
  input  logic [TW-1:0] tag,
  input  logic [WW-1:0] rd_word,
  output logic          hit,
  output logic [31:0]   rdata,
  input  logic          wr_en,
  input  logic [WW-1:0] wr_word,
  input  logic [31:0]   wr_data,
  input  logic          set_valid,
  input  logic          clr_valid
);

  logic [LINES-1:0] valid;
  logic [TW-1:0]    tags  [LINES];
  logic [31:0]      words [LINES][WPL];

  assign hit   = valid[index] && (tags[index] == tag);
  assign rdata = words[index][rd_word];

  always_ff @(posedge clock) begin
    if (reset)
      valid <= '0;
    else if (set_valid)
      valid[index] <= 1'b1;
    else if (clr_valid)
      valid[index] <= 1'b0;
  end

  always_ff @(posedge clock) begin
    if (set_valid)
      tags[index] <= tag;
    if (wr_en)
      words[index][wr_word] <= wr_data;
  end

endmodule

// File: rtl/dcache_controller.sv
// rtl/dcache_controller.sv - direct-mapped write-through cache FSM; define DCACHE_STATS_EN for hit/miss counters
module dcache_controller
  import dcache_pkg::*;
#(
  parameter int LINES          = DEF_LINES,
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_read,
  input  logic        cpu_write,
  output logic [31:0] cpu_rdata,
  output logic        stall,
  output logic [31:0] mem_address,
  output logic [31:0] mem_value,
  input  logic [31:0] mem_data,
  output logic        mem_write,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int OFF = off_width(WORDS_PER_LINE);
  localparam int IW  = index_width(LINES);
  localparam int TW  = tag_width(LINES, WORDS_PER_LINE);
  localparam int WW  = $clog2(WORDS_PER_LINE);

  state_t          state;
  logic [WW-1:0]   beat;
  logic [IW-1:0]   cpu_index;
  logic [TW-1:0]   cpu_tag;
  logic [WW-1:0]   cpu_word;
  logic            rd_req, hit, last_beat;
  logic [31:0]     line_word;
  logic            st_wen, st_set, st_clr;
  logic [WW-1:0]   st_word;
  logic [31:0]     st_wdata;

  assign cpu_index = IW'(addr_index(cpu_addr, OFF));
  assign cpu_tag   = TW'(addr_tag(cpu_addr, OFF + IW));
  assign cpu_word  = WW'(addr_word(cpu_addr));
  assign rd_req    = cpu_read & ~cpu_write;
  assign last_beat = &beat;

  dcache_line_store #(
    .LINES(LINES), .WPL(WORDS_PER_LINE), .IW(IW), .TW(TW), .WW(WW)
  ) u_store (
    .clock    (clock),
    .reset    (reset),
    .index    (cpu_index),
    .tag      (cpu_tag),
    .rd_word  (cpu_word),
    .hit      (hit),
    .rdata    (line_word),
    .wr_en    (st_wen),
    .wr_word  (st_word),
    .wr_data  (st_wdata),
    .set_valid(st_set),
    .clr_valid(st_clr)
  );

  always_comb begin
    stall       = 1'b0;
    mem_write   = 1'b0;
    mem_address = word_align(cpu_addr);
    mem_value   = cpu_wdata;
    cpu_rdata   = '0;
    st_wen      = 1'b0;
    st_word     = cpu_word;
    st_wdata    = cpu_wdata;
    st_set      = 1'b0;
    st_clr      = 1'b0;
    case (state)
      IDLE: begin
        stall  = cpu_write | (rd_req & ~hit);
        // Drop the victim before refilling so a half-written line can never hit.
        st_clr = rd_req & ~hit;
        if (rd_req & hit)
          cpu_rdata = line_word;
      end
      FILL: begin
        stall       = 1'b1;
        mem_address = line_base(cpu_addr, OFF) | (32'(beat) << 2);
        st_wen      = 1'b1;
        st_word     = beat;
        st_wdata    = mem_data;
        st_set      = last_beat;
      end
      WRITE: begin
        mem_write = 1'b1;
        st_wen    = hit;
      end
      default: ;
    endcase
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] hits, misses;
  logic        just_filled;
  assign hit_count  = hits;
  assign miss_count = misses;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      beat  <= '0;
`ifdef DCACHE_STATS_EN
      hits        <= '0;
      misses      <= '0;
      just_filled <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (cpu_write)
            state <= WRITE;
          else if (rd_req & ~hit) begin
            state <= FILL;
            beat  <= '0;
          end
`ifdef DCACHE_STATS_EN
          just_filled <= 1'b0;
          if (rd_req & ~hit)
            misses <= misses + 32'd1;
          // The completion right after a fill belongs to the miss, not a hit.
          if (rd_req & hit & ~just_filled)
            hits <= hits + 32'd1;
`endif
        end
        FILL: begin
          beat <= beat + 1'b1;
          if (last_beat) begin
            state <= IDLE;
`ifdef DCACHE_STATS_EN
            just_filled <= 1'b1;
`endif
          end
        end
        WRITE:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/dcache_controller.md
# dcache_controller

Direct-mapped, write-through, no-write-allocate data cache controller that sits between the pipeline's memory stage and the byte-addressed, big-endian unified RAM. It is the initiator on the RAM's port: it drives address, value and write, and samples the RAM's combinational read data. The pipeline receives a single `stall` signal and holds its request stable while `stall` is high.

## Interface
- `LINES`, 8: number of cache lines; power of two, ≥2.
- `WORDS_PER_LINE`, 4: 32-bit words per line; power of two, ≥2.
- `clock` in 1: single clock; all state updates on posedge.
- `reset` in 1: synchronous, active-high.
- `cpu_addr` in 32: byte address; bits [1:0] ignored (word-aligned).
- `cpu_wdata` in 32: store data.
- `cpu_read` in 1: load request.
- `cpu_write` in 1: store request; wins if both request inputs are high.
- `cpu_rdata` out 32: load data; valid when `cpu_read`=1 and `stall`=0; 0 on a non-hit.
- `stall` out 1: combinational; 1 = request not completed this cycle.
- `mem_address` out 32: RAM byte address.
- `mem_value` out 32: RAM write data.
- `mem_data` in 32: RAM combinational read data.
- `mem_write` out 1: RAM write strobe.
- `hit_count` out 32: read-hit counter (see Configuration).
- `miss_count` out 32: read-miss counter (see Configuration).

## Operation
- Address split: offset = [OFF-1:0] with OFF = 2+log2(WORDS_PER_LINE); index = next log2(LINES) bits; tag = the remaining upper bits.
- Per line: valid bit, tag, and WORDS_PER_LINE data words.
- FSM states are IDLE, FILL and WRITE.
- IDLE, read hit: `stall`=0 and `cpu_rdata` = the selected word in the same cycle.
- IDLE, read miss: `stall`=1; go to FILL with beat=0.
- IDLE, write: `stall`=1; go to WRITE.
- FILL: `mem_address` = {cpu tag, index, beat, 2'b00}. At each edge, capture `mem_data` into word[beat]. After the last beat, set valid, write the tag, and return to IDLE. `stall`=1 throughout.
- WRITE: `mem_write`=1, `mem_address`=`cpu_addr` with [1:0] forced to 00, `mem_value`=`cpu_wdata`. `stall`=0, so the store completes this cycle.
  - On a tag hit, the cached word is also updated at the same edge.
  - On a miss, no allocation is made.
  - Next state is IDLE.
- IDLE with no request: `mem_address`=`cpu_addr`, `mem_write`=0, `stall`=0.
- Reset takes effect from any state, including mid-FILL. It forces IDLE, beat=0, all valid bits=0 and both counters=0. A partially filled line stays invalid.

## Timing
- Read hit: 0 stall cycles.
- Read miss: 1 + WORDS_PER_LINE stall cycles (IDLE detect, W FILL beats), then hit in IDLE.
- Store: exactly 1 stall cycle (IDLE), then completes in WRITE. `mem_write` is high for exactly one cycle per store.
- Immediately after reset: state IDLE, `mem_write`=0, `cpu_rdata`=0. `stall`=0 unless a request is present.
- A request must be held stable while `stall`=1. A request that changes during FILL is undefined, and the bench must not do this.
- Back-to-back requests: the cycle after WRITE or after the FILL completion may carry a new request with no bubble.

## Configuration
- `DCACHE_STATS_EN` defined:
  - `miss_count` increments on every IDLE→FILL transition.
  - `hit_count` increments on each read completed in IDLE that did not just come from FILL. A one-cycle "just-filled" flag suppresses the count on the first completion after a fill.
  - Both counters are 32-bit and wrap.
- Not defined: both outputs are tied to 0 and no counter flops exist. Ports stay present so instantiation is unchanged.

## Structure
- Package `dcache_pkg` holds:
  - state enum (IDLE, FILL, WRITE);
  - localparam derivation for OFF, index width and tag width;
  - address field extraction functions.
- Sub-module `dcache_line_store` holds the valid/tag/data arrays, with combinational lookup (hit, word out) and synchronous word write and line-valid set/clear.
- The FSM, memory mux and counters live in the top.

## Test plan
All scenarios use `LINES`=8 and `WORDS_PER_LINE`=4.
- Cold read: RAM word 0x40 = 0xDEADBEEF. After reset, read 0x40.
  - `stall` high for 5 cycles; `mem_address` = 0x40, 0x44, 0x48, 0x4C across FILL.
  - Then `cpu_rdata`=0xDEADBEEF with `stall`=0.
  - A following read of 0x44 hits with 0 stall.
- Conflict: alternate reads of 0x40 and 0xC0 (same index 4, different tag) → every access misses, 5 stall cycles each.
- Write hit: after caching 0x40, write 0x48 with 0x12345678.
  - One stall cycle, then `mem_write`=1 for one cycle with address 0x48 and value 0x12345678.
  - A read of 0x48 then hits and returns 0x12345678.
- Write miss: write 0x200 with 0xCAFEF00D → RAM bytes at 0x200..0x203 = CA FE F0 0D with no FILL. A following read of 0x200 misses and returns 0xCAFEF00D.
- Reset mid-fill: assert `reset` during the 2nd FILL beat of a read of 0x40.
  - Next cycle: IDLE, `mem_write`=0.
  - Re-reading 0x40 misses again (5 stall cycles).
- Stats (`DCACHE_STATS_EN`): run the cold-read scenario → `miss_count`=1, `hit_count`=1 (0x44 only). Without the macro, both read 0.
